// File: rtl/jpeg_pkg.sv
// Shared JPEG encoder types and constants used by the run-length encoder.
package jpeg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DC   = 2'd1,
    SCAN = 2'd2,
    EOB  = 2'd3
  } rle_state_t;

  localparam logic [3:0] RLE_ZRL_RUN = 4'd15;
  localparam logic [3:0] RLE_EOB_RUN = 4'd0;

endpackage

// File: rtl/block_rle_encoder_tail_detect.sv
// rle_tail_detect: reports whether any nonzero-mask bit sits at an index >= idx.
// Kept separate so the wide shift + OR-reduce can be timed and tested alone.
module rle_tail_detect #(
  parameter int N  = 64,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] idx,
  output logic          any_tail
);

  logic [N-1:0] shifted;

  // Drop everything below idx, then ask whether anything is left.
  always_comb begin
    shifted  = mask >> idx;
    any_tail = |shifted;
  end

endmodule

// File: rtl/block_rle_encoder.sv
// block_rle_encoder: serializes one quantized zigzag block into (run, value)
// symbols: DC, AC with zero runs, ZRL for 16-zero stretches, EOB for a zero tail.
// Optional build macro BLOCK_RLE_DC_DPCM_EN: DC symbol carries coef[0] minus the
// previous block's DC (modulo 2^COEF_W) instead of the raw value.
// BLOCK_SIZE default normally comes from sys_defs.svh; a local fallback keeps the
// file standalone.
`ifndef BLOCK_BUFF_SIZE
`define BLOCK_BUFF_SIZE 64
`endif

module block_rle_encoder
  import jpeg_pkg::*;
#(
  parameter int BLOCK_SIZE = `BLOCK_BUFF_SIZE,
  parameter int COEF_W     = 12
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               blk_valid,
  output logic                               blk_ready,
  input  logic [BLOCK_SIZE-1:0][COEF_W-1:0]  blk_data,
  output logic                               sym_valid,
  input  logic                               sym_ready,
  output logic [3:0]                         sym_run,
  output logic signed [COEF_W-1:0]           sym_value,
  output logic                               sym_freq,
  output logic                               sym_last,
  output logic                               busy
);

  localparam int              IW       = $clog2(BLOCK_SIZE);
  localparam logic [IW-1:0]   LAST_IDX = IW'(BLOCK_SIZE - 1);

  rle_state_t                          state, nxt;
  logic [BLOCK_SIZE-1:0][COEF_W-1:0]   coef_q;
  logic [BLOCK_SIZE-1:0]               nz_mask;
  logic [IW-1:0]                       idx;
  logic [3:0]                          zcnt;

  logic              tail_any;
  logic              cur_zero;
  logic [COEF_W-1:0] dc_val;
  logic              idx_inc, zcnt_inc, zcnt_clr;

  rle_tail_detect #(.N(BLOCK_SIZE), .IW(IW)) u_tail (
    .mask     (nz_mask),
    .idx      (idx),
    .any_tail (tail_any)
  );

`ifdef BLOCK_RLE_DC_DPCM_EN
  logic [COEF_W-1:0] dc_pred;

  // Predictor tracks the last DC actually handed to the consumer.
  always_ff @(posedge clk) begin
    if (rst)
      dc_pred <= '0;
    else if (state == DC && sym_ready)
      dc_pred <= coef_q[0];
  end

  assign dc_val = coef_q[0] - dc_pred;
`else
  assign dc_val = coef_q[0];
`endif

  assign cur_zero = ~nz_mask[idx];
  assign busy     = (state != IDLE);

  // Next-state and symbol presentation; outputs depend only on registered state,
  // so they hold stable while the consumer stalls.
  always_comb begin
    nxt       = state;
    blk_ready = 1'b0;
    sym_valid = 1'b0;
    sym_run   = RLE_EOB_RUN;
    sym_value = '0;
    sym_freq  = 1'b0;
    sym_last  = 1'b0;
    idx_inc   = 1'b0;
    zcnt_inc  = 1'b0;
    zcnt_clr  = 1'b0;
    case (state)
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) nxt = DC;
      end
      DC: begin
        sym_valid = 1'b1;
        sym_value = dc_val;
        if (sym_ready) nxt = (|nz_mask[BLOCK_SIZE-1:1]) ? SCAN : EOB;
      end
      SCAN: begin
        if (cur_zero && !tail_any) begin
          nxt = EOB;
        end else if (cur_zero && zcnt != RLE_ZRL_RUN) begin
          zcnt_inc = 1'b1;
          idx_inc  = 1'b1;
        end else if (cur_zero) begin
          sym_valid = 1'b1;
          sym_run   = RLE_ZRL_RUN;
          sym_freq  = 1'b1;
          if (sym_ready) begin
            zcnt_clr = 1'b1;
            idx_inc  = 1'b1;
          end
        end else begin
          sym_valid = 1'b1;
          sym_run   = zcnt;
          sym_value = coef_q[idx];
          sym_freq  = 1'b1;
          sym_last  = (idx == LAST_IDX);
          if (sym_ready) begin
            zcnt_clr = 1'b1;
            // Last coefficient nonzero: the receiver closes the block on wrap.
            if (idx == LAST_IDX) nxt = IDLE;
            else                 idx_inc = 1'b1;
          end
        end
      end
      EOB: begin
        sym_valid = 1'b1;
        sym_run   = RLE_EOB_RUN;
        sym_freq  = 1'b1;
        sym_last  = 1'b1;
        if (sym_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State, block buffer, scan index and zero counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      coef_q  <= '0;
      nz_mask <= '0;
      idx     <= '0;
      zcnt    <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && blk_valid) begin
        coef_q <= blk_data;
        for (int i = 0; i < BLOCK_SIZE; i++)
          nz_mask[i] <= (blk_data[i] != '0);
        idx  <= IW'(1);
        zcnt <= '0;
      end else begin
        if (idx_inc)  idx  <= idx + IW'(1);
        if (zcnt_clr) zcnt <= '0;
        else if (zcnt_inc) zcnt <= zcnt + 4'd1;
      end
    end
  end

endmodule

// File: doc/block_rle_encoder.md
Name: block_rle_encoder

Overview:
Transmit-side counterpart of the coefficient block buffer. It accepts one complete quantized block of BLOCK_SIZE zigzag-ordered coefficients and serializes it into (run, value) symbols for the Huffman/VLI encoder:
- one DC symbol;
- AC symbols with zero-run counts;
- ZRL (run 15, value 0) for each 16-zero stretch;
- EOB (run 0, value 0) when only zeros remain.

The symbol stream is exactly what the block buffer's wr_en/run/vli_value/freq interface consumes.

Parameters:
- BLOCK_SIZE, default `BLOCK_BUFF_SIZE (64): coefficients per block.
- COEF_W, default 12: signed coefficient width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- blk_valid  in  1  producer offers a full block.
- blk_ready  out  1  encoder can accept a block (IDLE only).
- blk_data  in  [BLOCK_SIZE-1:0][COEF_W-1:0]  signed coefficients, index 0 = DC.
- sym_valid  out  1  symbol present.
- sym_ready  in  1  consumer accepts symbol.
- sym_run  out  4  zero run preceding the value.
- sym_value  out  COEF_W signed  coefficient value (0 for ZRL/EOB).
- sym_freq  out  1  0 = DC symbol, 1 = AC/ZRL/EOB.
- sym_last  out  1  final symbol of the block.
- busy  out  1  block in progress (state != IDLE).

Behaviour:
- Reset: state IDLE; blk_ready=1; sym_valid, sym_run, sym_value, sym_freq, sym_last, busy = 0; internal buffer, nonzero mask, idx and zcnt cleared.
- Handshakes: a transfer occurs when valid&&ready on a rising edge. While sym_valid=1 and sym_ready=0, sym_run, sym_value, sym_freq and sym_last hold stable. Only one block is in flight; blocks do not overlap.
- State IDLE:
  - blk_ready=1.
  - On block accept: latch blk_data, latch nz_mask[i] = (blk_data[i] != 0), set idx=1, zcnt=0, go to DC.
  - Latency: first DC symbol is valid exactly 1 cycle after block accept.
- State DC:
  - Present run=0, value=coef[0], freq=0, last=0. A DC value of 0 is still emitted as a normal DC symbol.
  - On handshake: go to EOB if nz_mask[BLOCK_SIZE-1:1] == 0, else go to SCAN.
- State SCAN: examines coef[idx] each cycle. Priority order:
  - (a) coef[idx]==0 and no nonzero at any index >= idx: go to EOB, no output this cycle.
  - (b) coef[idx]==0 and zcnt<15: zcnt++, idx++, no output.
  - (c) coef[idx]==0 and zcnt==15: present ZRL (run=15, value=0, freq=1). On handshake: zcnt=0, idx++.
  - (d) coef[idx]!=0: present run=zcnt, value=coef[idx], freq=1, last=(idx==BLOCK_SIZE-1). On handshake: zcnt=0. If idx==BLOCK_SIZE-1, go to IDLE (no EOB, since the receiver ends the block on wrap); otherwise idx++.
  - Throughput: each zero costs 1 cycle without output; each output symbol costs at least 1 cycle.
- ZRL emission: a ZRL is emitted only when a later nonzero exists. Trailing zeros always collapse into a single EOB.
- State EOB: present run=0, value=0, freq=1, last=1. On handshake, go to IDLE.
- Width rules: idx is $clog2(BLOCK_SIZE) bits; zcnt is 4 bits and never exceeds 15.
- Reset mid-block: the in-flight block is abandoned, no EOB is emitted, and all outputs return to reset values on the next edge.
- blk_valid asserted while not IDLE: ignored (blk_ready=0); the producer must hold the block until accepted.

Optional Feature:
BLOCK_RLE_DC_DPCM_EN
- Defined:
  - The DC symbol value is coef[0] - dc_pred, computed modulo 2^COEF_W (wraps, no saturation).
  - dc_pred updates to coef[0] when the DC symbol handshakes.
  - dc_pred clears to 0 on rst.
- Undefined: the DC value is coef[0] unmodified and no predictor register exists.

Decomposition:
- Shared package (jpeg_pkg): rle_state_t enum {IDLE, DC, SCAN, EOB}; constants RLE_ZRL_RUN=4'd15 and RLE_EOB_RUN=4'd0.
- BLOCK_SIZE default comes from `BLOCK_BUFF_SIZE in sys_defs.svh.
- One sub-module, rle_tail_detect: combinational "any nz_mask bit at index >= idx" (mask shift plus OR-reduce). It is isolated for timing and unit test.

Test Plan:
- DC=5, all AC=0, sym_ready=1 → (0,5,f0), then (0,0,f1,last). Block accept to last symbol = 3 cycles.
- DC=-7, coef[1]=3, coef[20]=-2 → (0,-7,f0), (0,3), ZRL (15,0), (2,-2), EOB (0,0,last).
- Only coef[63]=7, DC=0 → (0,0,f0), three ZRLs, (14,7,last). No EOB; busy drops the next cycle.
- Backpressure: sym_ready=0 for 5 cycles during the DC symbol and during a ZRL → outputs stable, no skipped or duplicated symbols; stream matches the no-stall case.
- rst asserted mid-SCAN → next cycle IDLE, blk_ready=1, sym_valid=0. A new block then encodes correctly from DC.
- With BLOCK_RLE_DC_DPCM_EN: consecutive blocks with DC 100, 90, -2048 → DC values 100, -10, and 2^12 wrap of (-2048-90) = 1958.
